// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
// Boot loader fed by a UART receiver. After an arm pulse it reads a 32-bit
// big-endian word count N, then N big-endian 32-bit words, and writes them
// to consecutive memory word addresses starting at BASE_ADDR. When the
// session ends it sends one status byte: 8'hAA on success, 8'h55 on error.
//
// Ports
//   clk        : clock, rising edge
//   rstn       : synchronous active-low reset
//   start      : arm pulse; begins a session from IDLE, DONE or ERR
//   rx_data    : received byte
//   rx_valid   : one-cycle strobe qualifying rx_data / rx_ferr
//   rx_ferr    : framing error flag for the strobed byte
//   mem_we     : one-cycle memory write strobe
//   mem_addr   : write word address
//   mem_wdata  : write data
//   tx_data    : status byte for the transmitter
//   tx_valid   : tx_data valid; held until tx_ready is seen
//   tx_ready   : transmitter accepts tx_data
//   busy       : session in progress (LEN or DATA)
//   done       : load finished successfully
//   err        : load aborted (framing error or oversize length)
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// LEN   | collecting the 4-byte word count, then judging it
// DATA  | collecting data words and writing them to memory
// DONE  | all N words written; status 8'hAA offered
// ERR   | framing error or N too large; status 8'h55 offered
// ---------------------------------------------------------------------------
module uart_loader #(
   parameter int          ADDR_W    = 15,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_ferr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [32:0]       MAX_WORDS = 33'd1 << ADDR_W;
   localparam logic [7:0]        ST_OK     = 8'hAA;
   localparam logic [7:0]        ST_BAD    = 8'h55;
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [23:0]         r_shift;
   logic [1:0]          r_byte_cnt;
   logic [31:0]         r_len;
   logic                r_len_rdy;
   logic [ADDR_W:0]     r_index;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_tx_valid;
   logic [7:0]          r_tx_data;

   logic                w_start_ok;
   logic                w_in_load;
   logic                w_byte_ok;
   logic                w_bad_byte;
   logic [31:0]         w_word;
   logic                w_last_write;
   logic                w_enter_done;
   logic                w_enter_err;

   assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE ||
                                   r_state == S_ERR);
   assign w_in_load    = (r_state == S_LEN) || (r_state == S_DATA);
   assign w_byte_ok    = w_in_load && rx_valid && !rx_ferr;
   assign w_bad_byte   = w_in_load && rx_valid && rx_ferr;
   assign w_word       = {r_shift, rx_data};
   // r_index already counts the write being strobed this cycle
   assign w_last_write = r_mem_we && ({1'b0, r_len} == 33'(r_index));
   assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);
   assign w_enter_err  = (r_state != S_ERR)  && (w_state_nxt == S_ERR);

   // state register
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) w_state_nxt = S_LEN;
         end
         S_LEN: begin
            if (w_bad_byte) begin
               w_state_nxt = S_ERR;
            end else if (r_len_rdy) begin
               // length is judged the cycle after its last byte arrives
               if (r_len == 32'd0)                    w_state_nxt = S_DONE;
               else if ({1'b0, r_len} > MAX_WORDS)   w_state_nxt = S_ERR;
               else                                   w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bad_byte)        w_state_nxt = S_ERR;
            else if (w_last_write) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      busy      = (r_state == S_LEN) || (r_state == S_DATA);
      done      = (r_state == S_DONE);
      err       = (r_state == S_ERR);
      mem_we    = r_mem_we;
      mem_addr  = r_mem_addr;
      mem_wdata = r_mem_wdata;
      tx_valid  = r_tx_valid;
      tx_data   = r_tx_data;
   end

   // byte assembly, length capture and memory writes
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_shift     <= '0;
         r_byte_cnt  <= '0;
         r_len       <= '0;
         r_len_rdy   <= 1'b0;
         r_index     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= 1'b0;
         if (w_start_ok) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_len_rdy  <= 1'b0;
            r_index    <= '0;
         end else if (w_byte_ok) begin
            r_shift    <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
               if (r_state == S_LEN && !r_len_rdy) begin
                  r_len     <= w_word;
                  r_len_rdy <= 1'b1;
               end else if (r_state == S_DATA) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= BASE + r_index[ADDR_W-1:0];
                  r_mem_wdata <= w_word;
                  r_index     <= r_index + (ADDR_W+1)'(1);
               end
            end
         end
      end
   end

   // status byte: raised on entering DONE/ERR, dropped on handshake or re-arm
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else if (w_start_ok) begin
         r_tx_valid <= 1'b0;
      end else if (w_enter_done) begin
         r_tx_valid <= 1'b1;
         r_tx_data  <= ST_OK;
      end else if (w_enter_err) begin
         r_tx_valid <= 1'b1;
         r_tx_data  <= ST_BAD;
      end else if (r_tx_valid && tx_ready) begin
         r_tx_valid <= 1'b0;
      end
   end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, word address of the first program word.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  arm pulse; starts a load session.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data and rx_ferr are valid.
REQ-008 SHALL have port rx_ferr  input  1  framing error for the byte strobed by rx_valid.
REQ-009 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  write word address.
REQ-011 SHALL have port mem_wdata  output  32  write data.
REQ-012 SHALL have port tx_data  output  8  status byte for the UART transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data is valid; held until accepted.
REQ-014 SHALL have port tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-015 SHALL have port busy  output  1  high in LEN and DATA states.
REQ-016 SHALL have port done  output  1  high in DONE state.
REQ-017 SHALL have port err  output  1  high in ERR state.

Function
REQ-018 SHALL implement states IDLE, LEN, DATA, DONE, ERR.
REQ-019 SHALL move from IDLE, DONE or ERR to LEN on start, clearing the byte counter, word index and length register; start in LEN/DATA SHALL be ignored.
REQ-020 SHALL ignore rx_valid in IDLE, DONE and ERR.
REQ-021 SHALL assemble bytes big-endian: first byte of each group of four goes to bits [31:24], the fourth to bits [7:0].
REQ-022 SHALL, in LEN, collect 4 bytes as word count N (unsigned 32-bit).
REQ-023 SHALL go LEN->DONE when N==0, LEN->ERR when N > 2**ADDR_W, otherwise LEN->DATA, evaluated in the cycle after the fourth byte's rx_valid.
REQ-024 SHALL, in DATA, assert mem_we for exactly one cycle, the cycle after the fourth byte of each word, with mem_wdata the assembled word and mem_addr = (BASE_ADDR + index) mod 2**ADDR_W, index starting at 0.
REQ-025 SHALL increment index after each write and enter DONE in the same cycle as the N-th write strobe.
REQ-026 SHALL treat a byte with rx_valid and rx_ferr both high as error: discard the byte, perform no further mem_we, and enter ERR on the next cycle, from LEN or DATA.
REQ-027 SHALL, on entering DONE, present tx_data=8'hAA; on entering ERR, tx_data=8'h55; tx_valid rises in the cycle the state is entered.
REQ-028 SHALL hold tx_valid and tx_data stable until the cycle tx_valid and tx_ready are both high, then deassert tx_valid in the next cycle; exactly one status byte per session.
REQ-029 SHALL, on start before a pending status byte is accepted, drop tx_valid and begin the new session.
REQ-030 SHALL keep mem_we low outside DATA; mem_addr and mem_wdata are don't-care when mem_we is low.

Reset
REQ-031 SHALL, while rstn is low at a clock edge, enter IDLE with mem_we=0, mem_addr=0, mem_wdata=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0, counters cleared.
REQ-032 SHALL abandon any session on reset mid-load; a partly assembled word is never written.

Verification
REQ-033 start; bytes 00 00 00 02, 11 22 33 44, A5 A5 00 01 -> mem_we at addr 0 with 11223344, addr 1 with A5A50001; done=1; tx AA sent once.
REQ-034 start; bytes 00 00 00 00 -> no mem_we; DONE; tx_data=AA.
REQ-035 ADDR_W=4: length 00 00 00 11 -> ERR, no mem_we, tx_data=55; length 00 00 00 10 -> 16 writes, addr 0..15.
REQ-036 start; length 1; third data byte with rx_ferr=1 -> no mem_we, err=1, tx_data=55; then start + valid session -> loads normally.
REQ-037 tx_ready held low 20 cycles after DONE -> tx_valid and tx_data=AA stable throughout; single handshake when tx_ready rises.
REQ-038 rstn low after 2 of 4 data bytes -> all outputs at reset values; later bytes without start ignored.
